// File: rtl/periph_demux_mt.sv
// Routes one core data port to NB_TARGETS peripherals by address window + selector; unmapped hits get an error reply.
// Request path is combinational (same-cycle grant); responses return in order, earliest 1 cycle after grant.
// Stalls the core (no grant) while the tracking FIFO is full or the new destination differs from the in-flight one.
module periph_demux_mt #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    BE_WIDTH        = DATA_WIDTH/8,
  parameter int                    NB_TARGETS      = 4,
  parameter int                    SEL_LSB         = 10,
  parameter int                    SEL_WIDTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] WIN_MASK        = 32'h000F_C000,
  parameter logic [ADDR_WIDTH-1:0] WIN_BASE        = 32'h0000_4000,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA       = 32'hBADA_CCE5
) (
  input  logic                                  clk,
  input  logic                                  rst_i,
  // core side
  input  logic                                  data_req_i,
  input  logic [ADDR_WIDTH-1:0]                 data_add_i,
  input  logic                                  data_wen_i,
  input  logic [DATA_WIDTH-1:0]                 data_wdata_i,
  input  logic [BE_WIDTH-1:0]                   data_be_i,
  output logic                                  data_gnt_o,
  output logic                                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0]                 data_r_rdata_o,
  output logic                                  data_r_opc_o,
  // peripheral side
  output logic [NB_TARGETS-1:0]                 per_req_o,
  output logic [NB_TARGETS-1:0][ADDR_WIDTH-1:0] per_add_o,
  output logic [NB_TARGETS-1:0]                 per_wen_o,
  output logic [NB_TARGETS-1:0][DATA_WIDTH-1:0] per_wdata_o,
  output logic [NB_TARGETS-1:0][BE_WIDTH-1:0]   per_be_o,
  input  logic [NB_TARGETS-1:0]                 per_gnt_i,
  input  logic [NB_TARGETS-1:0]                 per_r_valid_i,
  input  logic [NB_TARGETS-1:0][DATA_WIDTH-1:0] per_r_rdata_i,
  input  logic [NB_TARGETS-1:0]                 per_r_opc_i,
  // status
  output logic                                  spurious_rsp_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o
);

  // ID NB_TARGETS is the internal error responder
  localparam int                   ID_W      = $clog2(NB_TARGETS+1);
  localparam int                   PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int                   CNT_W     = $clog2(MAX_OUTSTANDING+1);
  localparam logic [ID_W-1:0]      ERR_ID    = ID_W'(NB_TARGETS);
  localparam logic [SEL_WIDTH-1:0] SEL_LIMIT = SEL_WIDTH'(NB_TARGETS);
  localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]     PTR_LAST  = PTR_W'(MAX_OUTSTANDING-1);

  // destination tracking FIFO
  logic [ID_W-1:0]      r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic [ID_W-1:0]      r_last_dest;
  logic                 r_spur;

  logic                 w_hit;
  logic [SEL_WIDTH-1:0] w_sel;
  logic [ID_W-1:0]      w_dest;
  logic                 w_dest_err;
  logic                 w_can_issue;
  logic                 w_tgt_gnt;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic [ID_W-1:0]      w_head;
  logic                 w_rsp_vld;
  logic [DATA_WIDTH-1:0] w_rsp_dat;
  logic                 w_rsp_opc;
  logic                 w_spur;

  // address decode
  assign w_hit      = ((data_add_i & WIN_MASK) == WIN_BASE);
  assign w_sel      = data_add_i[SEL_LSB +: SEL_WIDTH];
  assign w_dest     = (w_hit && (w_sel < SEL_LIMIT)) ? ID_W'(w_sel) : ERR_ID;
  assign w_dest_err = (w_dest == ERR_ID);

  // only one destination may be in flight at a time, which keeps responses ordered
  assign w_can_issue = !rst_i && (r_count < CNT_MAX) &&
                       ((r_count == '0) || (w_dest == r_last_dest));

  // request fields are broadcast; only the request strobe is steered
  assign per_add_o   = {NB_TARGETS{data_add_i}};
  assign per_wen_o   = {NB_TARGETS{data_wen_i}};
  assign per_wdata_o = {NB_TARGETS{data_wdata_i}};
  assign per_be_o    = {NB_TARGETS{data_be_i}};

  // steer request to the decoded target and pick up its grant; error dest grants itself
  always_comb begin
    per_req_o = '0;
    w_tgt_gnt = 1'b0;
    for (int k = 0; k < NB_TARGETS; k++) begin
      if (w_dest == ID_W'(k)) begin
        per_req_o[k] = data_req_i & w_can_issue;
        w_tgt_gnt    = per_gnt_i[k];
      end
    end
    data_gnt_o = w_can_issue & (w_dest_err ? data_req_i : w_tgt_gnt);
  end

  assign w_push  = data_req_i & data_gnt_o;
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rptr];

  // response mux from the head destination; stray target responses are flagged and dropped
  always_comb begin
    w_rsp_vld = 1'b0;
    w_rsp_dat = '0;
    w_rsp_opc = 1'b0;
    w_spur    = 1'b0;
    for (int k = 0; k < NB_TARGETS; k++) begin
      if (!w_empty && (w_head == ID_W'(k))) begin
        w_rsp_vld = per_r_valid_i[k];
        w_rsp_dat = per_r_rdata_i[k];
        w_rsp_opc = per_r_opc_i[k];
      end else if (per_r_valid_i[k]) begin
        w_spur = 1'b1;
      end
    end
    // an error entry at the head was pushed at least one cycle ago, so answer it now
    if (!w_empty && (w_head == ERR_ID)) begin
      w_rsp_vld = 1'b1;
      w_rsp_dat = ERR_RDATA;
      w_rsp_opc = 1'b1;
    end
  end

  assign w_pop          = w_rsp_vld & !rst_i;
  assign data_r_valid_o = w_pop;
  assign data_r_rdata_o = w_rsp_dat;
  assign data_r_opc_o   = w_rsp_opc;
  assign outstanding_o  = rst_i ? '0 : r_count;
  assign spurious_rsp_o = r_spur;

  // FIFO pointers, fill level, last pushed destination and spurious pulse
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_last_dest <= '0;
      r_spur      <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_dest;
        r_wptr         <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PTR_W'(1);
        r_last_dest    <= w_dest;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_spur <= w_spur;
    end
  end

endmodule

// File: tb/tb_periph_demux_mt.sv
// Directed bench for periph_demux_mt: fixed stimulus steps, response scoreboard checked by a negedge monitor.
// Inputs change 1 time unit after the rising edge; combinational outputs are checked 1 unit later.
// Target responses are driven by hand from the step sequence.
module tb_periph_demux_mt;

  localparam int NB = 4;

  logic                clk;
  logic                rst_i;
  logic                data_req_i;
  logic [31:0]         data_add_i;
  logic                data_wen_i;
  logic [31:0]         data_wdata_i;
  logic [3:0]          data_be_i;
  logic                data_gnt_o;
  logic                data_r_valid_o;
  logic [31:0]         data_r_rdata_o;
  logic                data_r_opc_o;
  logic [NB-1:0]       per_req_o;
  logic [NB-1:0][31:0] per_add_o;
  logic [NB-1:0]       per_wen_o;
  logic [NB-1:0][31:0] per_wdata_o;
  logic [NB-1:0][3:0]  per_be_o;
  logic [NB-1:0]       per_gnt_i;
  logic [NB-1:0]       per_r_valid_i;
  logic [NB-1:0][31:0] per_r_rdata_i;
  logic [NB-1:0]       per_r_opc_i;
  logic                spurious_rsp_o;
  logic [1:0]          outstanding_o;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        opc;
  } rsp_t;
  rsp_t sb[$];

  periph_demux_mt dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .data_req_i     (data_req_i),
    .data_add_i     (data_add_i),
    .data_wen_i     (data_wen_i),
    .data_wdata_i   (data_wdata_i),
    .data_be_i      (data_be_i),
    .data_gnt_o     (data_gnt_o),
    .data_r_valid_o (data_r_valid_o),
    .data_r_rdata_o (data_r_rdata_o),
    .data_r_opc_o   (data_r_opc_o),
    .per_req_o      (per_req_o),
    .per_add_o      (per_add_o),
    .per_wen_o      (per_wen_o),
    .per_wdata_o    (per_wdata_o),
    .per_be_o       (per_be_o),
    .per_gnt_i      (per_gnt_i),
    .per_r_valid_i  (per_r_valid_i),
    .per_r_rdata_i  (per_r_rdata_i),
    .per_r_opc_i    (per_r_opc_i),
    .spurious_rsp_o (spurious_rsp_o),
    .outstanding_o  (outstanding_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_rsp(input logic [31:0] d, input logic opc);
    rsp_t e;
    e.d   = d;
    e.opc = opc;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] a);
    data_req_i   = 1'b1;
    data_add_i   = a;
    data_wen_i   = 1'b1;
    data_wdata_i = 32'h0;
    data_be_i    = 4'hF;
  endtask

  task automatic idle();
    data_req_i = 1'b0;
  endtask

  task automatic rsp(input int k, input logic [31:0] d);
    per_r_valid_i    = '0;
    per_r_valid_i[k] = 1'b1;
    per_r_rdata_i[k] = d;
    per_r_opc_i      = '0;
  endtask

  task automatic norsp();
    per_r_valid_i = '0;
  endtask

  // response monitor: every valid response must match the oldest expected entry
  initial begin
    forever begin
      @(negedge clk);
      if (data_r_valid_o === 1'b1) begin
        n_chk++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL rsp_unexpected observed=%0h expected=none", data_r_rdata_o);
        end
        if (sb.size() != 0) begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_rdata", data_r_rdata_o, e.d);
          chk("rsp_opc", data_r_opc_o, e.opc);
        end
      end
    end
  end

  initial begin
    rst_i         = 1'b1;
    data_req_i    = 1'b0;
    data_add_i    = '0;
    data_wen_i    = 1'b1;
    data_wdata_i  = '0;
    data_be_i     = '0;
    per_gnt_i     = '1;
    per_r_valid_i = '0;
    per_r_rdata_i = '0;
    per_r_opc_i   = '0;

    // reset: a request held during reset must not leak out
    drive_req(32'h0000_4400);
    tick();
    tick();
    #1;
    chk("rst_per_req", per_req_o, 4'b0000);
    chk("rst_gnt", data_gnt_o, 1'b0);
    chk("rst_valid", data_r_valid_o, 1'b0);
    chk("rst_outstanding", outstanding_o, 2'd0);
    rst_i = 1'b0;
    idle();
    tick();
    #1;
    chk("idle_outstanding", outstanding_o, 2'd0);
    chk("idle_spurious", spurious_rsp_o, 1'b0);
    chk("idle_rdata", data_r_rdata_o, 32'h0);
    chk("idle_opc", data_r_opc_o, 1'b0);

    // T1: read to target 1, response two cycles after grant
    drive_req(32'h0000_4400);
    #1;
    chk("t1_per_req", per_req_o, 4'b0010);
    chk("t1_gnt", data_gnt_o, 1'b1);
    exp_rsp(32'h0000_1234, 1'b0);
    tick();
    idle();
    #1;
    chk("t1_out_c1", outstanding_o, 2'd1);
    chk("t1_valid_c1", data_r_valid_o, 1'b0);
    tick();
    rsp(1, 32'h0000_1234);
    #1;
    chk("t1_valid_c2", data_r_valid_o, 1'b1);
    tick();
    norsp();
    #1;
    chk("t1_out_end", outstanding_o, 2'd0);
    tick();

    // T2: two reads to target 0 fill the FIFO, the third stalls until a pop
    drive_req(32'h0000_4000);
    #1;
    chk("t2_gnt_c0", data_gnt_o, 1'b1);
    exp_rsp(32'h0000_00A0, 1'b0);
    tick();
    drive_req(32'h0000_4000);
    #1;
    chk("t2_gnt_c1", data_gnt_o, 1'b1);
    chk("t2_out_c1", outstanding_o, 2'd1);
    exp_rsp(32'h0000_00A1, 1'b0);
    tick();
    drive_req(32'h0000_4004);
    #1;
    chk("t2_out_c2", outstanding_o, 2'd2);
    chk("t2_stall_gnt", data_gnt_o, 1'b0);
    chk("t2_stall_req", per_req_o, 4'b0000);
    tick();
    rsp(0, 32'h0000_00A0);
    #1;
    chk("t2_out_c3", outstanding_o, 2'd2);
    chk("t2_full_gnt", data_gnt_o, 1'b0);
    chk("t2_valid_c3", data_r_valid_o, 1'b1);
    tick();
    rsp(0, 32'h0000_00A1);
    #1;
    chk("t2_out_c4", outstanding_o, 2'd1);
    chk("t2_gnt_c4", data_gnt_o, 1'b1);
    chk("t2_req_c4", per_req_o, 4'b0001);
    exp_rsp(32'h0000_00A2, 1'b0);
    tick();
    idle();
    norsp();
    #1;
    chk("t2_out_c5", outstanding_o, 2'd1);
    tick();
    tick();
    rsp(0, 32'h0000_00A2);
    #1;
    chk("t2_valid_c7", data_r_valid_o, 1'b1);
    tick();
    norsp();
    #1;
    chk("t2_out_end", outstanding_o, 2'd0);
    tick();

    // T3: switching target is held off until the previous target drains
    drive_req(32'h0000_4000);
    #1;
    chk("t3_gnt_c0", data_gnt_o, 1'b1);
    exp_rsp(32'h0000_00B0, 1'b0);
    tick();
    drive_req(32'h0000_4800);
    #1;
    chk("t3_hold_gnt", data_gnt_o, 1'b0);
    chk("t3_hold_req", per_req_o, 4'b0000);
    chk("t3_hold_out", outstanding_o, 2'd1);
    tick();
    rsp(0, 32'h0000_00B0);
    #1;
    chk("t3_hold2_gnt", data_gnt_o, 1'b0);
    chk("t3_hold2_req", per_req_o, 4'b0000);
    tick();
    norsp();
    #1;
    chk("t3_issue_req", per_req_o, 4'b0100);
    chk("t3_issue_gnt", data_gnt_o, 1'b1);
    exp_rsp(32'h0000_00C2, 1'b0);
    tick();
    idle();
    rsp(2, 32'h0000_00C2);
    #1;
    chk("t3_valid", data_r_valid_o, 1'b1);
    tick();
    norsp();
    tick();

    // T4: unmapped selector then window miss, back-to-back error replies
    drive_req(32'h0000_5000);
    #1;
    chk("t4_gnt_sel4", data_gnt_o, 1'b1);
    chk("t4_req_sel4", per_req_o, 4'b0000);
    chk("t4_valid_c0", data_r_valid_o, 1'b0);
    exp_rsp(32'hBADA_CCE5, 1'b1);
    tick();
    drive_req(32'h0000_0000);
    #1;
    chk("t4_gnt_miss", data_gnt_o, 1'b1);
    chk("t4_req_miss", per_req_o, 4'b0000);
    chk("t4_valid_c1", data_r_valid_o, 1'b1);
    chk("t4_rdata_c1", data_r_rdata_o, 32'hBADA_CCE5);
    chk("t4_opc_c1", data_r_opc_o, 1'b1);
    exp_rsp(32'hBADA_CCE5, 1'b1);
    tick();
    idle();
    #1;
    chk("t4_valid_c2", data_r_valid_o, 1'b1);
    tick();
    #1;
    chk("t4_valid_c3", data_r_valid_o, 1'b0);
    chk("t4_out_end", outstanding_o, 2'd0);
    chk("t4_rdata_empty", data_r_rdata_o, 32'h0);
    chk("t4_opc_empty", data_r_opc_o, 1'b0);

    // T5: stray response with nothing outstanding
    rsp(3, 32'h0000_DEAD);
    #1;
    chk("t5_valid", data_r_valid_o, 1'b0);
    chk("t5_out", outstanding_o, 2'd0);
    tick();
    norsp();
    #1;
    chk("t5_spur_on", spurious_rsp_o, 1'b1);
    chk("t5_out_after", outstanding_o, 2'd0);
    tick();
    #1;
    chk("t5_spur_off", spurious_rsp_o, 1'b0);

    // T6: reset with two requests in flight; late response is spurious
    drive_req(32'h0000_4000);
    #1;
    chk("t6_gnt_c0", data_gnt_o, 1'b1);
    tick();
    drive_req(32'h0000_4000);
    #1;
    chk("t6_gnt_c1", data_gnt_o, 1'b1);
    tick();
    idle();
    rst_i = 1'b1;
    #1;
    chk("t6_rst_out", outstanding_o, 2'd0);
    chk("t6_rst_valid", data_r_valid_o, 1'b0);
    tick();
    rst_i = 1'b0;
    rsp(0, 32'h0000_0077);
    #1;
    chk("t6_post_out", outstanding_o, 2'd0);
    chk("t6_late_valid", data_r_valid_o, 1'b0);
    tick();
    norsp();
    drive_req(32'h0000_4400);
    #1;
    chk("t6_spur", spurious_rsp_o, 1'b1);
    chk("t6_new_gnt", data_gnt_o, 1'b1);
    chk("t6_new_req", per_req_o, 4'b0010);
    exp_rsp(32'h0000_0055, 1'b0);
    tick();
    idle();
    rsp(1, 32'h0000_0055);
    #1;
    chk("t6_new_valid", data_r_valid_o, 1'b1);
    tick();
    norsp();
    tick();
    tick();

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
